// File: rtl/memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : memory_lsu
// Brief    : In-order load/store unit for a multi-lane issue bundle; serves
//            memory lanes one request at a time, lowest lane first.
//            Optional macro MEM_MISALIGN_CHECK_EN enables misalignment traps.
// Revision : 1.0 - initial release
// ============================================================================
module memory_lsu #(
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           mem_read_ena,
  input  logic [LANES-1:0]           mem_write_ena,
  input  logic [LANES-1:0][2:0]      mem_type,
  input  logic [LANES-1:0][DW-1:0]   addr,
  input  logic [LANES-1:0][DW-1:0]   write_data,
  input  logic [LANES-1:0][DW-1:0]   result,
  input  logic [LANES-1:0]           write_reg_need,
  input  logic [LANES-1:0][4:0]      write_reg_addr,
  output logic                       dreq_valid,
  input  logic                       dreq_ready,
  output logic                       dreq_we,
  output logic [DW-1:0]              dreq_addr,
  output logic [3:0]                 dreq_wstrb,
  output logic [DW-1:0]              dreq_wdata,
  input  logic                       dresp_valid,
  input  logic [DW-1:0]              dresp_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0][DW-1:0]   cmt_result,
  output logic [LANES-1:0]           cmt_write_reg_need,
  output logic [LANES-1:0][4:0]      cmt_write_reg_addr,
  output logic [LANES-1:0]           cmt_exc
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LANES-1:0]          r_load;
  logic [LANES-1:0]          r_store;
  logic [LANES-1:0]          r_pend;
  logic [LANES-1:0][2:0]     r_type;
  logic [LANES-1:0][DW-1:0]  r_addr;
  logic [LANES-1:0][DW-1:0]  r_wdata;
  logic [LANES-1:0][DW-1:0]  r_result;
  logic [LANES-1:0]          r_wrn;
  logic [LANES-1:0][4:0]     r_wra;

  logic                      w_accept;
  logic [LANES-1:0]          w_supp;
  logic [LW-1:0]             w_cur;
  logic [LANES-1:0]          w_cur_onehot;
  logic [LANES-1:0]          w_pend_left;
  logic [2:0]                w_cur_type;
  logic [1:0]                w_cur_a;
  logic [DW-1:0]             w_cur_wdata;
  logic                      w_is_byte;
  logic                      w_is_half;
  logic [15:0]               w_lo;
  logic [DW-1:0]             w_load_ext;
  logic [3:0]                w_strb;

  assign w_accept = (r_state == S_IDLE) && in_valid;

`ifdef MEM_MISALIGN_CHECK_EN
  logic [LANES-1:0] w_mis;
  logic [LANES-1:0] w_exc_in;
  logic [LANES-1:0] r_exc;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_mis
      assign w_mis[g] = (mem_read_ena[g] | mem_write_ena[g]) &&
                        (((mem_type[g][1:0] == 2'b01) && addr[g][0]) ||
                         (mem_type[g][1] && (addr[g][1:0] != 2'b00)));
    end
  endgenerate

  // The first misaligned lane traps; it and every later lane are squashed.
  always_comb begin
    w_supp   = '0;
    w_exc_in = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == 0) begin
        w_exc_in[i] = w_mis[i];
        w_supp[i]   = w_mis[i];
      end else begin
        w_exc_in[i] = w_mis[i] & ~w_supp[i-1];
        w_supp[i]   = w_mis[i] | w_supp[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_exc <= '0;
    end else if (w_accept) begin
      r_exc <= w_exc_in;
    end
  end

  assign cmt_exc = r_exc;
`else
  assign w_supp  = '0;
  assign cmt_exc = '0;
`endif

  // Lowest pending lane; descending loop so the smallest index wins.
  always_comb begin
    w_cur = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_cur = LW'(i);
      end
    end
  end

  assign w_cur_onehot = LANES'(1) << w_cur;
  assign w_pend_left  = r_pend & ~w_cur_onehot;
  assign w_cur_type   = r_type[w_cur];
  assign w_cur_a      = r_addr[w_cur][1:0];
  assign w_cur_wdata  = r_wdata[w_cur];
  assign w_is_byte    = (w_cur_type[1:0] == 2'b00);
  assign w_is_half    = (w_cur_type[1:0] == 2'b01);

  always_comb begin
    w_strb = 4'b1111;
    if (w_is_byte) begin
      w_strb = 4'b0001 << w_cur_a;
    end else if (w_is_half) begin
      w_strb = 4'b0011 << w_cur_a;
    end
  end

  always_comb begin
    w_lo       = 16'(dresp_rdata >> {w_cur_a, 3'b000});
    w_load_ext = dresp_rdata;
    if (w_is_byte) begin
      w_load_ext = {{(DW-8){~w_cur_type[2] & w_lo[7]}}, w_lo[7:0]};
    end else if (w_is_half) begin
      w_load_ext = {{(DW-16){~w_cur_type[2] & w_lo[15]}}, w_lo};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = (((mem_read_ena | mem_write_ena) & ~w_supp) != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (dreq_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dresp_valid) begin
          w_state_nxt = (w_pend_left != '0) ? S_REQ : S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wrn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wrn <= write_reg_need & ~w_supp;
      end
    end
  end

  // Payload registers; only meaningful while the FSM is out of IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_load   <= mem_read_ena & ~mem_write_ena;
      r_store  <= mem_write_ena;
      r_pend   <= (mem_read_ena | mem_write_ena) & ~w_supp;
      r_type   <= mem_type;
      r_addr   <= addr;
      r_wdata  <= write_data;
      r_result <= result;
      r_wra    <= write_reg_addr;
    end else if ((r_state == S_WAIT) && dresp_valid) begin
      if (r_load[w_cur]) begin
        r_result[w_cur] <= w_load_ext;
      end
      r_pend <= w_pend_left;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign dreq_valid = (r_state == S_REQ);
  assign dreq_we    = (r_state == S_REQ) & r_store[w_cur];
  assign dreq_wstrb = (r_state == S_REQ) ? w_strb : 4'b0000;
  assign dreq_addr  = {r_addr[w_cur][DW-1:2], 2'b00};

  always_comb begin
    dreq_wdata = w_cur_wdata;
    if (w_is_byte) begin
      dreq_wdata = {(DW/8){w_cur_wdata[7:0]}};
    end else if (w_is_half) begin
      dreq_wdata = {(DW/16){w_cur_wdata[15:0]}};
    end
  end

  assign cmt_result         = r_result;
  assign cmt_write_reg_need = r_wrn;
  assign cmt_write_reg_addr = r_wra;

endmodule
`default_nettype wire

// File: tb/tb_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_lsu
// Brief    : Directed self-checking bench for memory_lsu (LANES=2, DW=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_lsu;

  localparam int LANES = 2;
  localparam int DW    = 32;

  logic                      clk;
  logic                      resetn;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES-1:0]          mem_read_ena;
  logic [LANES-1:0]          mem_write_ena;
  logic [LANES-1:0][2:0]     mem_type;
  logic [LANES-1:0][DW-1:0]  addr;
  logic [LANES-1:0][DW-1:0]  write_data;
  logic [LANES-1:0][DW-1:0]  result;
  logic [LANES-1:0]          write_reg_need;
  logic [LANES-1:0][4:0]     write_reg_addr;
  logic                      dreq_valid;
  logic                      dreq_ready;
  logic                      dreq_we;
  logic [DW-1:0]             dreq_addr;
  logic [3:0]                dreq_wstrb;
  logic [DW-1:0]             dreq_wdata;
  logic                      dresp_valid;
  logic [DW-1:0]             dresp_rdata;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES-1:0][DW-1:0]  cmt_result;
  logic [LANES-1:0]          cmt_write_reg_need;
  logic [LANES-1:0][4:0]     cmt_write_reg_addr;
  logic [LANES-1:0]          cmt_exc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  memory_lsu #(.LANES(LANES), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read_ena(mem_read_ena), .mem_write_ena(mem_write_ena),
    .mem_type(mem_type), .addr(addr), .write_data(write_data), .result(result),
    .write_reg_need(write_reg_need), .write_reg_addr(write_reg_addr),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .cmt_result(cmt_result), .cmt_write_reg_need(cmt_write_reg_need),
    .cmt_write_reg_addr(cmt_write_reg_addr), .cmt_exc(cmt_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_bundle();
    in_valid       = 1'b0;
    mem_read_ena   = '0;
    mem_write_ena  = '0;
    mem_type       = '0;
    addr           = '0;
    write_data     = '0;
    result         = '0;
    write_reg_need = '0;
    write_reg_addr = '0;
  endtask

  task automatic set_lane(input int l, input logic rd, input logic wr, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] res,
                          input logic wrn, input logic [4:0] wra);
    mem_read_ena[l]   = rd;
    mem_write_ena[l]  = wr;
    mem_type[l]       = t;
    addr[l]           = a;
    write_data[l]     = wd;
    result[l]         = res;
    write_reg_need[l] = wrn;
    write_reg_addr[l] = wra;
  endtask

  // Presents the bundle at a negedge; returns at the negedge after the accept edge.
  task automatic accept(output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok, output logic we, output logic [31:0] a,
                          output logic [3:0] st, output logic [31:0] wd);
    ok = 1'b0; we = 1'b0; a = '0; st = '0; wd = '0;
    for (int i = 0; i < 50; i++) begin
      if (dreq_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      we = dreq_we; a = dreq_addr; st = dreq_wstrb; wd = dreq_wdata;
      dreq_ready = 1'b1;
      @(negedge clk);
      dreq_ready = 1'b0;
    end
  endtask

  // Response is sampled dly cycles after the request handshake cycle.
  task automatic respond(input int dly, input logic [31:0] rd, output int early);
    early = 0;
    repeat (dly - 1) begin
      @(negedge clk);
      if (dreq_valid === 1'b1) early++;
    end
    dresp_valid = 1'b1;
    dresp_rdata = rd;
    @(negedge clk);
    dresp_valid = 1'b0;
    dresp_rdata = '0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, dreq_valid, dreq_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl got in_ready/out_valid/dreq_valid/we=%b want 1000",
               {in_ready, out_valid, dreq_valid, dreq_we});
    end
    n_tests++;
    if ({dreq_wstrb, cmt_exc, cmt_write_reg_need} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs got wstrb/exc/wrn=%h want 00", {dreq_wstrb, cmt_exc, cmt_write_reg_need});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_alu();
    bit ok; logic we; logic [31:0] a, wd; logic [3:0] st; int early;
    clear_bundle();
    set_lane(0, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 5'd1);
    set_lane(1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h0, 32'h5, 1'b1, 5'd2);
    accept(ok);
    if (!ok) begin n_fail++; $display("FAIL load_alu_accept got timeout"); end
    wait_req(ok, we, a, st, wd);
    n_tests++;
    if ({ok, we, a} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL load_alu_req got ok=%b we=%b addr=%h want 1 0 00000100", ok, we, a);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_alu_early_out got out_valid=%b want 0", out_valid);
    end
    respond(3, 32'hDEADBEEF, early);
    n_tests++;
    if (out_valid !== 1'b1 || (cyc - acc_cyc) != 5) begin
      n_fail++;
      $display("FAIL load_alu_latency got out_valid=%b after %0d cycles want 1 after 5", out_valid, cyc - acc_cyc);
    end
    n_tests++;
    if (early != 0 || dreq_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_alu_single_req got extra requests=%0d want 0", early);
    end
    n_tests++;
    if (cmt_result !== {32'h5, 32'hDEADBEEF} || cmt_write_reg_need !== 2'b11 ||
        cmt_write_reg_addr !== {5'd2, 5'd1}) begin
      n_fail++;
      $display("FAIL load_alu_cmt got result=%h wrn=%b wra=%h want 00000005deadbeef 11 041",
               cmt_result, cmt_write_reg_need, cmt_write_reg_addr);
    end
    release_out();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_alu_idle got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_store_then_load(input logic [2:0] ltype, input logic [31:0] exp);
    bit ok; logic we; logic [31:0] a, wd; logic [3:0] st; int early;
    clear_bundle();
    set_lane(0, 1'b0, 1'b1, 3'd0, 32'h203, 32'h000000AB, 32'h11, 1'b0, 5'd0);
    set_lane(1, 1'b1, 1'b0, ltype, 32'h203, 32'h0, 32'h0, 1'b1, 5'd7);
    accept(ok);
    if (!ok) begin n_fail++; $display("FAIL st_ld_accept got timeout"); end
    wait_req(ok, we, a, st, wd);
    n_tests++;
    if ({ok, we, a, st, wd} !== {1'b1, 1'b1, 32'h200, 4'b1000, 32'hABABABAB}) begin
      n_fail++;
      $display("FAIL st_ld_store got ok=%b we=%b addr=%h wstrb=%b wdata=%h want 1 1 00000200 1000 abababab",
               ok, we, a, st, wd);
    end
    respond(2, 32'h0, early);
    n_tests++;
    if (early != 0) begin
      n_fail++; $display("FAIL st_ld_order got load before store response count=%0d want 0", early);
    end
    wait_req(ok, we, a, st, wd);
    n_tests++;
    if ({ok, we, a} !== {1'b1, 1'b0, 32'h200}) begin
      n_fail++; $display("FAIL st_ld_load got ok=%b we=%b addr=%h want 1 0 00000200", ok, we, a);
    end
    respond(1, 32'hAB000000, early);
    wait_out(ok);
    n_tests++;
    if (!ok || cmt_result[1] !== exp || cmt_result[0] !== 32'h11) begin
      n_fail++;
      $display("FAIL st_ld_result type=%0d got ok=%b lane1=%h lane0=%h want 1 %h 00000011",
               ltype, ok, cmt_result[1], cmt_result[0], exp);
    end
    release_out();
  endtask

  task automatic test_stall();
    bit ok; int bad; int early; logic [68:0] p0; logic [DW+5:0] c0;
    clear_bundle();
    set_lane(0, 1'b0, 1'b1, 3'd1, 32'h302, 32'h0000BEEF, 32'h0, 1'b0, 5'd0);
    set_lane(1, 1'b0, 1'b0, 3'd0, 32'h0,   32'h0, 32'h77, 1'b1, 5'd9);
    accept(ok);
    if (!ok) begin n_fail++; $display("FAIL stall_accept got timeout"); end
    p0 = {dreq_we, dreq_addr, dreq_wstrb, dreq_wdata};
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (dreq_valid !== 1'b1 || {dreq_we, dreq_addr, dreq_wstrb, dreq_wdata} !== p0 || in_ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stall_req_stable got %0d unstable cycles want 0", bad);
    end
    n_tests++;
    if (p0 !== {1'b1, 32'h300, 4'b1100, 32'hBEEFBEEF}) begin
      n_fail++; $display("FAIL stall_req_payload got %h want 1_00000300_c_beefbeef", p0);
    end
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    respond(1, 32'h0, early);
    wait_out(ok);
    c0 = {cmt_result[1], cmt_write_reg_need, cmt_write_reg_addr[1]};
    clear_bundle();
    in_valid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {cmt_result[1], cmt_write_reg_need, cmt_write_reg_addr[1]} !== c0) bad++;
    end
    n_tests++;
    if (!ok || bad != 0 || c0 !== {32'h77, 2'b10, 5'd9}) begin
      n_fail++; $display("FAIL stall_done_stable got ok=%b unstable=%0d cmt=%h want 1 0 77/10/09", ok, bad, c0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_same_cycle_accept got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_no_mem();
    bit ok;
    clear_bundle();
    set_lane(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'hA, 1'b1, 5'd3);
    set_lane(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'hB, 1'b1, 5'd4);
    accept(ok);
    n_tests++;
    if (!ok || out_valid !== 1'b1 || dreq_valid !== 1'b0 || (cyc - acc_cyc) != 1) begin
      n_fail++;
      $display("FAIL no_mem_timing got ok=%b out_valid=%b dreq_valid=%b cycles=%0d want 1 1 0 1",
               ok, out_valid, dreq_valid, cyc - acc_cyc);
    end
    n_tests++;
    if (cmt_result !== {32'hB, 32'hA} || cmt_write_reg_addr !== {5'd4, 5'd3}) begin
      n_fail++;
      $display("FAIL no_mem_cmt got result=%h wra=%h want 0000000b0000000a 083", cmt_result, cmt_write_reg_addr);
    end
    release_out();
  endtask

  task automatic test_reset_in_wait();
    bit ok; logic we; logic [31:0] a, wd; logic [3:0] st; int bad;
    clear_bundle();
    set_lane(0, 1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1, 5'd5);
    accept(ok);
    wait_req(ok, we, a, st, wd);
    resetn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!ok || in_ready !== 1'b1 || cmt_write_reg_need !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_wait_idle got req_ok=%b in_ready=%b wrn=%b want 1 1 00", ok, in_ready, cmt_write_reg_need);
    end
    resetn = 1'b1;
    @(negedge clk);
    dresp_valid = 1'b1;
    dresp_rdata = 32'h12345678;
    @(negedge clk);
    dresp_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      if (out_valid !== 1'b0 || dreq_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_wait_late_resp got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_misalign();
    bit ok;
`ifdef MEM_MISALIGN_CHECK_EN
    int reqs;
`else
    logic we; logic [31:0] a, wd; logic [3:0] st; int early;
`endif
    clear_bundle();
    set_lane(0, 1'b1, 1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 1'b1, 5'd1);
    set_lane(1, 1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 1'b1, 5'd2);
    accept(ok);
`ifdef MEM_MISALIGN_CHECK_EN
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (dreq_valid === 1'b1) reqs++;
      if (out_valid === 1'b1) break;
      @(negedge clk);
    end
    n_tests++;
    if (reqs != 0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL misalign_reqs got reqs=%0d out_valid=%b want 0 1", reqs, out_valid);
    end
    n_tests++;
    if (cmt_exc !== 2'b01 || cmt_write_reg_need !== 2'b00) begin
      n_fail++; $display("FAIL misalign_exc got exc=%b wrn=%b want 01 00", cmt_exc, cmt_write_reg_need);
    end
`else
    wait_req(ok, we, a, st, wd);
    n_tests++;
    if ({ok, we, a, st} !== {1'b1, 1'b0, 32'h100, 4'b0110}) begin
      n_fail++; $display("FAIL misalign_req0 got ok=%b we=%b addr=%h wstrb=%b want 1 0 00000100 0110", ok, we, a, st);
    end
    respond(1, 32'h00FEDC00, early);
    wait_req(ok, we, a, st, wd);
    n_tests++;
    if ({ok, we, a} !== {1'b1, 1'b0, 32'h200}) begin
      n_fail++; $display("FAIL misalign_req1 got ok=%b we=%b addr=%h want 1 0 00000200", ok, we, a);
    end
    respond(1, 32'hCAFEF00D, early);
    wait_out(ok);
    n_tests++;
    if (!ok || cmt_exc !== 2'b00 || cmt_write_reg_need !== 2'b11 ||
        cmt_result !== {32'hCAFEF00D, 32'hFFFFFEDC}) begin
      n_fail++;
      $display("FAIL misalign_off got ok=%b exc=%b wrn=%b result=%h want 1 00 11 cafef00dfffffedc",
               ok, cmt_exc, cmt_write_reg_need, cmt_result);
    end
`endif
    release_out();
  endtask

  initial begin
    clear_bundle();
    resetn      = 1'b0;
    dreq_ready  = 1'b0;
    dresp_valid = 1'b0;
    dresp_rdata = '0;
    out_ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_alu();
    test_store_then_load(3'd4, 32'h000000AB);
    test_store_then_load(3'd0, 32'hFFFFFFAB);
    test_stall();
    test_no_mem();
    test_reset_in_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
